// File: rtl/lfsr_prbs_checker_if.sv
// Serial PRBS receive bus between a bit source and lfsr_prbs_checker.
// The master drives in_valid/in_bit/clr_cnt; the slave (checker) returns its status.
// LFSR_CHK_STATUS_EN adds the sync_loss_cnt status signal.
interface lfsr_prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;
`ifdef LFSR_CHK_STATUS_EN
    logic [7:0]       sync_loss_cnt;

    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt, sync_loss_cnt
    );
    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt, sync_loss_cnt
    );
`else
    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt
    );
    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt
    );
`endif
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising Fibonacci LFSR PRBS checker.
// SEARCH: shift received bits into r, count consecutive correct predictions, lock at LOCK_CNT.
// LOCKED: r free-runs on its own prediction so one corrupted bit costs exactly one error;
//         LOSS_THRESH consecutive mismatches drop back to SEARCH.
// Optional macro LFSR_CHK_STATUS_EN adds sync_loss_cnt (saturating LOCKED->SEARCH count).
module lfsr_prbs_checker #(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] TAPS        = 7'h60,
    parameter int               LOCK_CNT    = 16,
    parameter int               LOSS_THRESH = 4,
    parameter int               CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_prbs_checker_if.slave bus
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  MISS_LOSS  = MISS_W'(LOSS_THRESH);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         sync_q, sync_d;
    logic               pred;
    logic               mism;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Prediction always uses r from before this bit's shift.
    assign pred      = ^(r_q & TAPS);
    assign mism      = bus.in_bit ^ pred;
    assign match_inc = match_q + 1'b1;
    assign miss_inc  = miss_q + 1'b1;

    // Next-state and next-output logic for the SEARCH/LOCKED machine and its counters.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sync_d      = sync_q;

        if (bus.in_valid) begin
            case (state_q)
                SEARCH: begin
                    r_d = {r_q[WIDTH-2:0], bus.in_bit};
                    if (fill_q != FILL_FULL) begin
                        // r does not yet hold WIDTH real bits: nothing to predict from.
                        fill_d = fill_q + 1'b1;
                    end else if (mism || (r_q == '0)) begin
                        // An all-zero r predicts zero forever; refuse to lock on it.
                        match_d = '0;
                    end else if (match_inc == MATCH_LOCK) begin
                        state_d = LOCKED;
                        match_d = '0;
                    end else begin
                        match_d = match_inc;
                    end
                end
                LOCKED: begin
                    r_d       = {r_q[WIDTH-2:0], pred};
                    bit_cnt_d = sat_inc(bit_cnt_q);
                    if (mism) begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        if (miss_inc == MISS_LOSS) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                            sync_d  = (&sync_q) ? sync_q : sync_q + 8'd1;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear wins over any increment in the same cycle; err_pulse is unaffected.
        if (bus.clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
            sync_d    = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            r_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sync_q      <= sync_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.bit_cnt   = bit_cnt_q;

`ifdef LFSR_CHK_STATUS_EN
    assign bus.sync_loss_cnt = sync_q;
`else
    logic unused_sync;
    assign unused_sync = ^sync_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: a PRBS7 source (seed 7'h7F) feeds two checkers,
// one with 16-bit counters and one with 3-bit counters for saturation.
module tb_lfsr_prbs_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_prbs_checker_if #(.CNT_W(16)) ifm ();
    lfsr_prbs_checker_if #(.CNT_W(3))  ifs ();

    lfsr_prbs_checker #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifm.slave));
    lfsr_prbs_checker #(.CNT_W(3))  dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

    int errors = 0;
    int checks = 0;
    logic [6:0] gs;

    typedef struct {
        int n;      // bits in this segment
        bit inv;    // invert every bit of the segment
        bit clr;    // clr_cnt on the last bit
        bit e_lock;
        bit e_pulse;
        int e_err;
        int e_bit;
        int e_sync;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic c);
        ifm.in_valid = v; ifm.in_bit = b; ifm.clr_cnt = c;
        ifs.in_valid = v; ifs.in_bit = b; ifs.clr_cnt = c;
        @(posedge clk);
        #1;
        ifm.in_valid = 1'b0; ifm.clr_cnt = 1'b0;
        ifs.in_valid = 1'b0; ifs.clr_cnt = 1'b0;
    endtask

    // PRBS7 generator: output MSB, shift left with feedback ^(s & 7'h60).
    task automatic send(input bit inv, input bit clr, input int gap);
        logic b;
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
        b  = gs[6];
        gs = {gs[5:0], ^(gs & 7'h60)};
        drive(1'b1, b ^ inv, clr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        gs  = 7'h7F;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_lock"},  32'(ifm.locked),    0);
        chk({nm, "_pulse"}, 32'(ifm.err_pulse), 0);
        chk({nm, "_err"},   32'(ifm.err_cnt),   0);
        chk({nm, "_bit"},   32'(ifm.bit_cnt),   0);
`ifdef LFSR_CHK_STATUS_EN
        chk({nm, "_sync"},  32'(ifm.sync_loss_cnt), 0);
`endif
    endtask

    initial begin
        int bad;
        ifm.in_valid = 0; ifm.in_bit = 0; ifm.clr_cnt = 0;
        ifs.in_valid = 0; ifs.in_bit = 0; ifs.clr_cnt = 0;
        gs = 7'h7F;

        // n, inv, clr, lock, pulse, err, bit, sync
        tbl[0]  = '{22, 0, 0, 0, 0, 0,  0, 0};  // one short of lock
        tbl[1]  = '{ 1, 0, 0, 1, 0, 0,  0, 0};  // bit #23 locks
        tbl[2]  = '{10, 0, 0, 1, 0, 0, 10, 0};
        tbl[3]  = '{66, 0, 0, 1, 0, 0, 76, 0};  // through stream bit 99
        tbl[4]  = '{ 1, 1, 0, 1, 1, 1, 77, 0};  // stream bit 100 inverted
        tbl[5]  = '{ 1, 0, 0, 1, 0, 1, 78, 0};  // pulse lasts one cycle
        tbl[6]  = '{ 1, 0, 1, 1, 0, 0,  0, 0};  // clr with clean bit
        tbl[7]  = '{ 3, 1, 0, 1, 1, 3,  3, 0};  // 3 misses: still locked
        tbl[8]  = '{ 1, 1, 0, 0, 1, 4,  4, 1};  // 4th miss: counted, lock lost
        tbl[9]  = '{22, 0, 0, 0, 0, 4,  4, 1};  // counters hold in SEARCH
        tbl[10] = '{ 1, 0, 0, 1, 0, 4,  4, 1};  // relock after 23 bits
        tbl[11] = '{ 5, 0, 0, 1, 0, 4,  9, 1};
        tbl[12] = '{ 1, 1, 1, 1, 1, 0,  0, 0};  // clr beats error; pulse still fires
        tbl[13] = '{ 1, 0, 0, 1, 0, 0,  1, 0};
        tbl[14] = '{ 1, 1, 0, 1, 1, 1,  2, 0};  // next error counts from 0
        tbl[15] = '{ 1, 0, 0, 1, 0, 1,  3, 0};

        // Reset state while rst is held.
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-zero stream must never lock.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (ifm.locked !== 1'b0) bad++;
        end
        chk("zeros_lock_cycles", 32'(bad), 0);
        chk_zero("zeros");

        // Continuous PRBS7 vectors.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < tbl[i].n; k++)
                send(tbl[i].inv, tbl[i].clr && (k == tbl[i].n - 1), 0);
            chk($sformatf("v%0d_lock", i),  32'(ifm.locked),    32'(tbl[i].e_lock));
            chk($sformatf("v%0d_pulse", i), 32'(ifm.err_pulse), 32'(tbl[i].e_pulse));
            chk($sformatf("v%0d_err", i),   32'(ifm.err_cnt),   32'(tbl[i].e_err));
            chk($sformatf("v%0d_bit", i),   32'(ifm.bit_cnt),   32'(tbl[i].e_bit));
`ifdef LFSR_CHK_STATUS_EN
            chk($sformatf("v%0d_sync", i),  32'(ifm.sync_loss_cnt), 32'(tbl[i].e_sync));
`endif
        end

        // Saturation on the 3-bit instance: 9 errors without losing lock.
        send(0, 1, 0);
        for (int j = 0; j < 3; j++) begin
            send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
        end
        chk("sat_main_err", 32'(ifm.err_cnt), 9);
        chk("sat_main_bit", 32'(ifm.bit_cnt), 12);
        chk("sat_main_lock", 32'(ifm.locked), 1);
        chk("sat_small_err", 32'(ifs.err_cnt), 7);
        chk("sat_small_bit", 32'(ifs.bit_cnt), 7);
        send(1, 0, 0);
        chk("sat_small_err_hold", 32'(ifs.err_cnt), 7);
        chk("sat_small_pulse", 32'(ifs.err_pulse), 1);
        chk("sat_main_err2", 32'(ifm.err_cnt), 10);

        // Sparse in_valid (every 3rd cycle), then reset mid-stream.
        do_reset();
        for (int k = 0; k < 22; k++) send(0, 0, 2);
        chk("sparse_prelock", 32'(ifm.locked), 0);
        send(0, 0, 2);
        chk("sparse_lock", 32'(ifm.locked), 1);
        chk("sparse_bit0", 32'(ifm.bit_cnt), 0);
        for (int k = 0; k < 17; k++) send(0, 0, 2);
        chk("sparse_bit40", 32'(ifm.bit_cnt), 17);
        chk("sparse_err40", 32'(ifm.err_cnt), 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("sparse_idle_pulse", 32'(ifm.err_pulse), 0);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 22; k++) send(0, 0, 2);
        chk("relock_pre", 32'(ifm.locked), 0);
        send(0, 0, 2);
        chk("relock", 32'(ifm.locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
